stream_demux_1ton: RTL and testbench
====================================

// Module: stream_demux_1toN
// PURPOSE
//  Parametrised, registered 1-to-N streaming demultiplexer; successor to the combinational 1-to-8 demux.
//  Routes each input beat (data + channel select) to one of NUM_CH output channels over valid/ready.
//  Each channel has a one-entry output register, so a stalled channel does not block the others.
//  Sits between a single producer and NUM_CH independent consumers; counts accepted and dropped beats.
// PARAMETERS
//  DATA_W  8   width of one data beat
//  NUM_CH  8   number of output channels, 2..16; need not be a power of two
//  SEL_W   3   select width, = $clog2(NUM_CH); set by instantiator, checked at elaboration
//  CNT_W   16  width of the saturating beat/drop counters
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              producer beat valid
//  in_ready   out  1              block accepts beat this cycle
//  in_data    in   DATA_W         beat payload
//  in_sel     in   SEL_W          destination channel index
//  out_valid  out  NUM_CH         per-channel beat valid
//  out_ready  in   NUM_CH         per-channel consumer ready
//  out_data   out  NUM_CH*DATA_W  channel k payload at [k*DATA_W +: DATA_W]
//  beat_cnt   out  CNT_W          beats delivered into channel registers, saturating
//  drop_cnt   out  CNT_W          beats dropped for out-of-range select, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, beat_cnt=0, drop_cnt=0. in_ready is combinational and 0 while rst=1.
//  - Handshake: a beat transfers on clk edge when in_valid & in_ready; the same rule applies per channel
//    with out_valid[k] & out_ready[k]. in_data/in_sel are sampled only on transfer.
//  - in_ready (rst=0), with s=in_sel:
//    s <  NUM_CH: in_ready = ~out_valid[s] | out_ready[s]  (register empty, or drained this same cycle).
//    s >= NUM_CH: in_ready = 1; the beat is discarded and drop_cnt increments; no out_valid changes.
//  - in_ready may depend on in_sel and out_ready; it must not depend on in_valid.
//  - Channel k register: load when an accepted beat has s==k: out_data[k] <= in_data, out_valid[k] <= 1.
//    Else, if out_ready[k]: out_valid[k] <= 0. Else hold. Load has priority over drain in the same cycle,
//    giving one beat per cycle of throughput per channel.
//  - Latency: accept at edge N -> out_valid[s]=1 with the data after edge N; 1 cycle.
//  - out_data[k] holds its last value while out_valid[k]=0; it is not cleared on drain.
//  - Unselected channels are unaffected by input traffic; they keep draining independently.
//  - Once out_valid[k]=1, it stays 1 and out_data[k] stays stable until out_ready[k] is sampled high.
//  - beat_cnt +1 per in-range accept; drop_cnt +1 per out-of-range accept; both stop at 2^CNT_W-1.
//  - Reset mid-operation: all pending channel beats are lost; state matches the reset values after the edge.
//  - in_valid=0: no state change except channel drains.
// STRUCTURE
//  - Package stream_demux_pkg: default widths, the saturating-increment function, and a NUM_CH
//    range-check constant.
//  - Sub-module stream_demux_slot: one-entry valid/data register with load/drain/hold.
//    Instantiated NUM_CH times in a generate loop. Top level holds the ready/decode logic and the counters.
// TESTING
//  T1 reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, counters 0.
//  T2 sweep: out_ready=all 1s; data=8'hA0+k, sel=k for k=0..7, one per cycle.
//     -> each out_valid[k] is high exactly 1 cycle after its accept, with data A0+k; beat_cnt=8.
//  T3 stall: out_ready[3]=0; send sel=3 data 11, then sel=3 data 22.
//     -> 11 held on ch3, in_ready=0 for the 2nd beat. A beat with sel=5 meanwhile is accepted.
//     Raise out_ready[3] -> 22 is accepted in that same cycle; ch3 shows 22 the next cycle.
//  T4 back-to-back: out_ready[2]=1; 4 beats to sel=2 on consecutive cycles
//     -> in_ready stays 1 and ch2 delivers 4 beats in 4 cycles, in order.
//  T5 out-of-range: NUM_CH=6, sel=6 and sel=7 -> in_ready=1, no out_valid, drop_cnt=2, beat_cnt unchanged.
//  T6 reset mid-stream: 3 channels full with out_ready=0, pulse rst 1 cycle -> all out_valid=0 next cycle.
//     Scoreboard: every accepted in-range beat emerges exactly once, on the right channel, in order.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// stream_demux_pkg
//   Shared definitions for the registered 1-to-N stream demultiplexer:
//   default widths, the legal channel-count range, the classification of an
//   input beat, and the saturating increment used by the beat/drop counters.
//   No ports; imported by stream_demux_slot and stream_demux_1ton.
// ----------------------------------------------------------------------------
package stream_demux_pkg;

  // Default geometry of the demux.
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NUM_CH = 8;
  localparam int DEFAULT_SEL_W  = 3;
  localparam int DEFAULT_CNT_W  = 16;

  // Legal channel-count range, checked when the top level elaborates.
  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;

  // The saturating increment works on a 32-bit carrier, so counters wider
  // than this are rejected at elaboration.
  localparam int CNT_W_MAX = 32;

  // What happens to the beat presented on the input this cycle.
  typedef enum logic [1:0] {
    BEAT_NONE  = 2'd0,
    BEAT_ROUTE = 2'd1,
    BEAT_DROP  = 2'd2
  } beat_kind_e;

  // Add one to a counter of 'width' bits, sticking at the all-ones value.
  // The limit is built one bit wider than the carrier so width == 32 works.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [32:0] maxVal;
    maxVal = (33'd1 << width) - 33'd1;
    if ({1'b0, value} >= maxVal) begin
      return value;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// ----------------------------------------------------------------------------
// stream_demux_slot
//   One-entry output register for a single demux channel. A beat is loaded
//   when the top level routes an accepted beat here; the entry is released
//   when the downstream consumer is ready. Load wins over drain, so a channel
//   can take a new beat in the same cycle its old one leaves, sustaining one
//   beat per cycle. The payload is not cleared on drain.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   synchronous, active-high reset
//     i_load   in   capture i_data this edge
//     i_data   in   payload to capture
//     i_ready  in   downstream consumer ready for this channel
//     o_valid  out  entry holds a beat
//     o_data   out  held payload
// ----------------------------------------------------------------------------
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Entry register: reset empties it and zeroes the payload. A load always
  // takes precedence; otherwise a ready consumer empties the entry while the
  // payload keeps its last value. With neither, the beat is held stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/stream_demux_1ton.sv
// ----------------------------------------------------------------------------
// stream_demux_1ton
//   Registered 1-to-N streaming demultiplexer. Each input beat carries a
//   channel select; beats for an existing channel go into that channel's
//   one-entry register, beats whose select is past the last channel are
//   accepted and discarded. A stalled channel only back-pressures beats that
//   target it. Saturating counters report delivered and dropped beats.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     in_valid   in   producer beat valid
//     in_ready   out  beat is accepted this cycle (combinational)
//     in_data    in   beat payload
//     in_sel     in   destination channel index
//     out_valid  out  per-channel beat valid
//     out_ready  in   per-channel consumer ready
//     out_data   out  channel k payload at [k*DATA_W +: DATA_W]
//     beat_cnt   out  beats delivered into channel registers, saturating
//     drop_cnt   out  beats dropped for an out-of-range select, saturating
// ----------------------------------------------------------------------------
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int SEL_W  = DEFAULT_SEL_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  // Reject geometries the datapath was not built for, before anything is
  // synthesised from them.
  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_badNumCh
    $error("stream_demux_1ton: NUM_CH=%0d outside %0d..%0d",
           NUM_CH, NUM_CH_MIN, NUM_CH_MAX);
  end
  if (SEL_W != $clog2(NUM_CH)) begin : g_badSelW
    $error("stream_demux_1ton: SEL_W=%0d but $clog2(NUM_CH)=%0d",
           SEL_W, $clog2(NUM_CH));
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_badCntW
    $error("stream_demux_1ton: CNT_W=%0d outside 1..%0d", CNT_W, CNT_W_MAX);
  end

  // Channel count widened by one bit so the range compare is exact even when
  // NUM_CH is a power of two and every select value is legal.
  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] w_selOneHot;
  logic [NUM_CH-1:0] w_chanFree;
  logic [NUM_CH-1:0] w_outValid;
  logic [NUM_CH-1:0] w_load;
  logic              w_selInRange;
  logic              w_inReady;
  logic              w_accept;
  beat_kind_e        w_beatKind;
  logic [CNT_W-1:0]  r_beatCnt;
  logic [CNT_W-1:0]  r_dropCnt;

  // Decode the select into a one-hot channel mask. Selects past the last
  // channel decode to all zeros, so they never touch a channel register and
  // the out_valid vector is never indexed out of range.
  always_comb begin
    w_selOneHot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_selOneHot[k] = (in_sel == SEL_W'(k));
    end
  end

  assign w_selInRange = ({1'b0, in_sel} < NUM_CH_EXT);

  // A channel can take a beat when its entry is empty or is being drained by
  // its consumer on this same edge.
  assign w_chanFree = ~w_outValid | out_ready;

  // Input ready looks only at the select and the target channel, never at
  // in_valid, so a producer may legally wait for ready before asserting
  // valid. Out-of-range beats are always taken so they can be counted and
  // discarded instead of wedging the input.
  always_comb begin
    w_inReady = 1'b0;
    if (rst) begin
      w_inReady = 1'b0;
    end else if (!w_selInRange) begin
      w_inReady = 1'b1;
    end else begin
      w_inReady = |(w_chanFree & w_selOneHot);
    end
  end

  assign in_ready = w_inReady;
  assign w_accept = in_valid & w_inReady;

  // Classify the transferring beat and steer its load strobe to the one
  // selected channel.
  always_comb begin
    w_beatKind = BEAT_NONE;
    w_load     = '0;
    if (w_accept) begin
      if (w_selInRange) begin
        w_beatKind = BEAT_ROUTE;
        w_load     = w_selOneHot;
      end else begin
        w_beatKind = BEAT_DROP;
      end
    end
  end

  // One entry register per channel; each drains on its own consumer ready,
  // independent of what the input is doing.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_valid (w_outValid[k]),
      .o_data  (out_data[k*DATA_W +: DATA_W])
    );
  end

  assign out_valid = w_outValid;

  // Delivered and dropped beat counters. Both stick at all-ones rather than
  // wrapping, so a long-running system never reports a misleadingly small
  // count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beatCnt <= '0;
      r_dropCnt <= '0;
    end else begin
      case (w_beatKind)
        BEAT_ROUTE: r_beatCnt <= CNT_W'(sat_inc(32'(r_beatCnt), CNT_W));
        BEAT_DROP:  r_dropCnt <= CNT_W'(sat_inc(32'(r_dropCnt), CNT_W));
        default: ;
      endcase
    end
  end

  assign beat_cnt = r_beatCnt;
  assign drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// ----------------------------------------------------------------------------
// tb_stream_demux_1ton
//   Self-checking bench for stream_demux_1ton built with six channels and a
//   3-bit select, so selects 6 and 7 exercise the drop path. Directed steps
//   follow the behaviour list, then a randomised stretch; every cycle is
//   compared against a behavioural model held in plain arrays and per-channel
//   scoreboard queues.
// ----------------------------------------------------------------------------
module tb_stream_demux_1ton;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 6;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]         beat_cnt;
  logic [CNT_W-1:0]         drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: which channels hold a beat, what each channel shows,
  // the two counters, and every accepted beat still owed to each consumer.
  logic [NUM_CH-1:0] mValid;
  logic [DATA_W-1:0] mData [NUM_CH];
  int                mBeats;
  int                mDrops;
  logic [DATA_W-1:0] sb [NUM_CH][$];

  stream_demux_1ton #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // A beat is taken unless it targets a real channel that is full and not
  // being drained; nothing is taken during reset.
  function automatic logic modelReady();
    int s;
    s = int'(in_sel);
    if (rst) return 1'b0;
    if (s >= NUM_CH) return 1'b1;
    return !mValid[s] || out_ready[s];
  endfunction

  task automatic modelReset();
    mValid = '0;
    mBeats = 0;
    mDrops = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      mData[k] = '0;
      sb[k].delete();
    end
  endtask

  task automatic checkOutput(input string step);
    check({step, ".in_ready"}, 32'(in_ready), 32'(modelReady()));
    check({step, ".out_valid"}, 32'(out_valid), 32'(mValid));
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("%s.out_data%0d", step, k),
            32'(out_data[k*DATA_W +: DATA_W]), 32'(mData[k]));
    end
    check({step, ".beat_cnt"}, 32'(beat_cnt), 32'(mBeats));
    check({step, ".drop_cnt"}, 32'(drop_cnt), 32'(mDrops));
  endtask

  // Advance the model across one clock edge using the values now on the pins.
  // Every beat handed to a consumer must be the oldest one owed to it.
  task automatic modelEdge(input string step);
    logic             take;
    int               s;
    logic [DATA_W-1:0] owed;
    take = in_valid && modelReady();
    s    = int'(in_sel);
    if (rst) begin
      modelReset();
      return;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (mValid[k] && out_ready[k]) begin
        if (sb[k].size() == 0) begin
          check($sformatf("%s.sb_owed%0d", step, k), 32'(0), 32'(1));
        end else begin
          owed = sb[k].pop_front();
          check($sformatf("%s.sb_order%0d", step, k),
                32'(out_data[k*DATA_W +: DATA_W]), 32'(owed));
        end
        mValid[k] = 1'b0;
      end
    end
    if (take) begin
      if (s < NUM_CH) begin
        mValid[s] = 1'b1;
        mData[s]  = in_data;
        sb[s].push_back(in_data);
        if (mBeats < CNT_MAX) mBeats++;
      end else begin
        if (mDrops < CNT_MAX) mDrops++;
      end
    end
  endtask

  // Drive one cycle of inputs, compare everything just before the edge,
  // then let the edge happen and return in the low phase.
  task automatic applyStimulus(input string step, input logic r, input logic v,
                               input int s, input int d,
                               input logic [NUM_CH-1:0] rdy);
    rst       = r;
    in_valid  = v;
    in_sel    = SEL_W'(s);
    in_data   = DATA_W'(d);
    out_ready = rdy;
    #1;
    checkOutput(step);
    modelEdge(step);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    modelReset();
    @(posedge clk);
    @(negedge clk);

    // T1: reset held with a valid beat waiting.
    for (int i = 0; i < 3; i++) applyStimulus("t1_reset", 1'b1, 1'b1, 2, 8'h5A, '1);

    // T2: sweep every select with all consumers ready; 6 and 7 are dropped.
    for (int k = 0; k < 8; k++) applyStimulus($sformatf("t2_sweep%0d", k), 1'b0, 1'b1, k, 8'hA0 + k, '1);
    applyStimulus("t2_idle", 1'b0, 1'b0, 0, 0, '1);
    check("t2_beat_cnt", 32'(beat_cnt), 32'(6));
    check("t2_drop_cnt", 32'(drop_cnt), 32'(2));

    // T3: channel 3 stalled; second beat is refused, channel 5 still flows.
    applyStimulus("t3_first", 1'b0, 1'b1, 3, 8'h11, 6'b110111);
    applyStimulus("t3_blocked", 1'b0, 1'b1, 3, 8'h22, 6'b110111);
    check("t3_refused", 32'(in_ready), 32'(0));
    applyStimulus("t3_other", 1'b0, 1'b1, 5, 8'h55, 6'b110111);
    check("t3_ch3_held", 32'(out_data[3*DATA_W +: DATA_W]), 32'(8'h11));
    applyStimulus("t3_release", 1'b0, 1'b1, 3, 8'h22, 6'b111111);
    check("t3_ch3_new", 32'(out_data[3*DATA_W +: DATA_W]), 32'(8'h22));
    applyStimulus("t3_idle", 1'b0, 1'b0, 0, 0, '1);

    // T4: four back-to-back beats into channel 2.
    for (int i = 0; i < 4; i++) applyStimulus($sformatf("t4_b2b%0d", i), 1'b0, 1'b1, 2, 8'hC0 + i, 6'b000100);
    applyStimulus("t4_tail", 1'b0, 1'b0, 0, 0, 6'b000100);

    // T5: out-of-range selects.
    applyStimulus("t5_sel6", 1'b0, 1'b1, 6, 8'hE6, '0);
    applyStimulus("t5_sel7", 1'b0, 1'b1, 7, 8'hE7, '0);
    applyStimulus("t5_idle", 1'b0, 1'b0, 0, 0, '0);

    // T6: fill three channels, then reset mid-stream.
    applyStimulus("t6_fill0", 1'b0, 1'b1, 0, 8'h70, '0);
    applyStimulus("t6_fill1", 1'b0, 1'b1, 1, 8'h71, '0);
    applyStimulus("t6_fill4", 1'b0, 1'b1, 4, 8'h74, '0);
    check("t6_full", 32'(out_valid), 32'(6'b010011));
    applyStimulus("t6_rst", 1'b1, 1'b0, 0, 0, '0);
    applyStimulus("t6_after", 1'b0, 1'b0, 0, 0, '0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 255),
                    NUM_CH'($urandom));
    end

    // Drain everything and confirm no beat is left owed.
    for (int i = 0; i < 3; i++) applyStimulus("drain", 1'b0, 1'b0, 0, 0, '1);
    for (int k = 0; k < NUM_CH; k++) check($sformatf("sb_empty%0d", k), 32'(sb[k].size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
